// File: rtl/fac_bus_pkg.sv
// Shared definitions for the factorial bus master: bus widths, slave register
// offsets and the sequencer state encoding.
package fac_bus_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] OFF_OPSTART  = 16'h0000;
   localparam logic [ADDR_W-1:0] OFF_OPCLEAR  = 16'h0001;
   localparam logic [ADDR_W-1:0] OFF_OPDONE   = 16'h0002;
   localparam logic [ADDR_W-1:0] OFF_INTR_EN  = 16'h0003;
   localparam logic [ADDR_W-1:0] OFF_OPERAND  = 16'h0004;
   localparam logic [ADDR_W-1:0] OFF_RESULT_H = 16'h0005;
   localparam logic [ADDR_W-1:0] OFF_RESULT_L = 16'h0006;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ1,
      ST_W_IE,
      ST_W_OP,
      ST_W_GO,
      ST_REL1,
      ST_WAIT,
      ST_REQ2,
      ST_R_H,
      ST_R_L,
      ST_CAP,
      ST_W_CLR,
      ST_FIN
   } fac_state_e;

endpackage

// File: rtl/fac_bus_xfer.sv
// Single-transaction bus engine: issues one address phase per granted cycle,
// holds address/data between accesses and flags read data on the following cycle.
module fac_bus_xfer
   import fac_bus_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              hold,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              m_req,
   input  logic              m_grant,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_dout,
   input  logic [DATA_W-1:0] m_din
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rd_pend_q, rd_pend_d;

   assign ack    = go & m_grant;
   assign m_req  = go | hold;
   assign m_wr   = go & wr;
   assign m_addr = go ? addr : addr_q;
   assign m_dout = (go & wr) ? wdata : dout_q;
   assign rvalid = rd_pend_q;
   assign rdata  = m_din;

   always_comb begin
      addr_d    = addr_q;
      dout_d    = dout_q;
      rd_pend_d = ack & ~wr;
      if (ack) begin
         addr_d = addr;
         if (wr) begin
            dout_d = wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         dout_q    <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         rd_pend_q <= rd_pend_d;
      end
   end

endmodule

// File: rtl/fac_bus_master.sv
// Bus-master sequencer for the factorial slave: program, wait, read result, clear.
// Define FAC_BUS_MASTER_POLL_EN to poll OPDONE instead of waiting on intr.
module fac_bus_master
   import fac_bus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h7000,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] operand,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [63:0] result,
   output logic        m_req,
   input  logic        m_grant,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [31:0] m_dout,
   input  logic [31:0] m_din,
   input  logic        intr
);

`ifdef FAC_BUS_MASTER_POLL_EN
   localparam logic IE_VAL = 1'b0;
   logic intr_unused;
   assign intr_unused = intr;
`else
   localparam logic IE_VAL = 1'b1;
`endif

   fac_state_e        state_q, state_d;
   logic [31:0]       op_q, op_d;
   logic [63:0]       result_q, result_d;
   logic              err_q, err_d;
   logic [31:0]       cnt_q, cnt_d;

   logic              go, hold, wr, ack, rvalid;
   logic [ADDR_W-1:0] x_off;
   logic [DATA_W-1:0] wdata, rdata;

   fac_bus_xfer u_xfer (
      .clk     (clk),
      .reset   (reset),
      .go      (go),
      .hold    (hold),
      .wr      (wr),
      .addr    (BASE_ADDR + x_off),
      .wdata   (wdata),
      .ack     (ack),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .m_req   (m_req),
      .m_grant (m_grant),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_dout  (m_dout),
      .m_din   (m_din)
   );

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_FIN);
   assign error  = done & err_q;
   assign result = result_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      result_d = result_q;
      err_d    = err_q;
      cnt_d    = '0;
      go       = 1'b0;
      hold     = 1'b0;
      wr       = 1'b0;
      x_off    = OFF_OPSTART;
      wdata    = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = operand;
               result_d = '0;
               err_d    = 1'b0;
               state_d  = ST_REQ1;
            end
         end
         ST_REQ1: begin
            hold = 1'b1;
            if (m_grant) state_d = ST_W_IE;
         end
         ST_W_IE: begin
            go    = 1'b1;
            wr    = 1'b1;
            x_off = OFF_INTR_EN;
            wdata = {31'b0, IE_VAL};
            if (ack) state_d = ST_W_OP;
         end
         ST_W_OP: begin
            go    = 1'b1;
            wr    = 1'b1;
            x_off = OFF_OPERAND;
            wdata = op_q;
            if (ack) state_d = ST_W_GO;
         end
         ST_W_GO: begin
            go    = 1'b1;
            wr    = 1'b1;
            x_off = OFF_OPSTART;
            wdata = 32'd1;
`ifdef FAC_BUS_MASTER_POLL_EN
            if (ack) state_d = ST_WAIT;
`else
            if (ack) state_d = ST_REL1;
`endif
         end
         ST_REL1: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 32'd1;
`ifdef FAC_BUS_MASTER_POLL_EN
            // Bus stays owned; a read is issued, then its data checked next cycle.
            hold = 1'b1;
            if (rvalid && rdata[0]) begin
               state_d = ST_R_H;
            end else if (cnt_q == TIMEOUT - 1) begin
               err_d   = 1'b1;
               state_d = ST_REQ2;
            end else if (!rvalid) begin
               go    = 1'b1;
               x_off = OFF_OPDONE;
            end
`else
            if (intr) begin
               state_d = ST_REQ2;
            end else if (cnt_q == TIMEOUT - 1) begin
               err_d   = 1'b1;
               state_d = ST_REQ2;
            end
`endif
         end
         ST_REQ2: begin
            hold = 1'b1;
            if (m_grant) state_d = err_q ? ST_W_CLR : ST_R_H;
         end
         ST_R_H: begin
            go    = 1'b1;
            x_off = OFF_RESULT_H;
            if (ack) state_d = ST_R_L;
         end
         ST_R_L: begin
            go    = 1'b1;
            x_off = OFF_RESULT_L;
            // rvalid is only set on the first R_L cycle, so a grant stall cannot recapture.
            if (rvalid) result_d[63:32] = rdata;
            if (ack) state_d = ST_CAP;
         end
         ST_CAP: begin
            hold = 1'b1;
            if (rvalid) result_d[31:0] = rdata;
            state_d = ST_W_CLR;
         end
         ST_W_CLR: begin
            go    = 1'b1;
            wr    = 1'b1;
            x_off = OFF_OPCLEAR;
            wdata = 32'd1;
            if (ack) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fac_bus_master.sv
// Directed bench for fac_bus_master with a cycle-level factorial slave model.
module tb_fac_bus_master;

   logic        clk = 1'b0;
   logic        reset, start, m_grant, intr;
   logic [31:0] operand, m_din;
   logic        busy, done, error, m_req, m_wr;
   logic [63:0] result;
   logic [15:0] m_addr;
   logic [31:0] m_dout;

   fac_bus_master #(.BASE_ADDR(16'h7000), .TIMEOUT(100)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .operand (operand),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .result  (result),
      .m_req   (m_req),
      .m_grant (m_grant),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_dout  (m_dout),
      .m_din   (m_din),
      .intr    (intr)
   );

   always #5 clk = ~clk;

`ifdef FAC_BUS_MASTER_POLL_EN
   localparam logic [31:0] IE_EXP = 32'd0;
   localparam int          LAT_TO = 107;
`else
   localparam logic [31:0] IE_EXP = 32'd1;
   localparam int          LAT_TO = 108;
`endif
   localparam int NDLY = 10;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          t0, lat, done_cyc, ndone;
   bit          done_seen, done_err;
   logic [63:0] done_res;
   bit          start_pend, rst_pend;
   logic [31:0] start_op;
   // slave model
   bit          slv_ie, armed, fire_en, slv_done, have_pend;
   int          intr_at;
   logic [31:0] slv_rh, slv_rl, pend_val;
   // grant stall
   bit          stall_en, stall_armed;
   int          stall_from, stall_to;
   logic [15:0] st_addr;
   logic        st_wr, st_req;
   // write log
   logic [15:0] wa [16];
   logic [31:0] wd [16];
   int          wc [16];
   int          wn;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      reset      = rst_pend;
      rst_pend   = 1'b0;
      start      = start_pend;
      operand    = start_pend ? start_op : 32'h0BAD_0000;
      start_pend = 1'b0;
      m_din      = have_pend ? pend_val : 32'hDEAD_BEEF;
      have_pend  = 1'b0;
      m_grant    = !(stall_armed && cyc >= stall_from && cyc < stall_to);
      slv_done   = armed && (cyc >= intr_at);
      intr       = slv_done && slv_ie;
      @(negedge clk);
      if (m_req && m_grant) begin
         if (m_wr) begin
            if (wn < 16) begin
               wa[wn] = m_addr;
               wd[wn] = m_dout;
               wc[wn] = cyc;
               wn++;
            end
            case (m_addr)
               16'h7003: slv_ie = m_dout[0];
               16'h7000: if (m_dout[0] && fire_en) begin
                  armed   = 1'b1;
                  intr_at = cyc + NDLY + 1;
               end
               16'h7001: if (m_dout[0]) armed = 1'b0;
               16'h7004: if (stall_en && !stall_armed) begin
                  stall_armed = 1'b1;
                  stall_from  = cyc + 1;
                  stall_to    = cyc + 4;
               end
               default: ;
            endcase
         end else begin
            have_pend = 1'b1;
            case (m_addr)
               16'h7002: pend_val = {31'b0, slv_done};
               16'h7005: pend_val = slv_rh;
               16'h7006: pend_val = slv_rl;
               default:  pend_val = 32'd0;
            endcase
         end
      end
      if (!m_grant) begin
         st_addr = m_addr;
         st_wr   = m_wr;
         st_req  = m_req;
      end
      if (done === 1'b1) begin
         ndone++;
         if (!done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_err  = error;
            done_res  = result;
         end
      end
   endtask

   task automatic slave_setup(input logic [31:0] rh, input logic [31:0] rl, input bit fire, input bit stall);
      slv_rh      = rh;
      slv_rl      = rl;
      fire_en     = fire;
      stall_en    = stall;
      stall_armed = 1'b0;
      armed       = 1'b0;
      slv_ie      = 1'b0;
      wn          = 0;
      ndone       = 0;
      done_seen   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wa[i] = '0;
         wd[i] = '0;
         wc[i] = 0;
      end
   endtask

   task automatic run_job(input logic [31:0] op, input logic [31:0] rh, input logic [31:0] rl,
                          input bit fire, input bit stall, input int inj_at);
      slave_setup(rh, rl, fire, stall);
      start_pend = 1'b1;
      start_op   = op;
      tick();
      t0 = cyc;
      for (int i = 1; i <= 300 && !done_seen; i++) begin
         if (i == inj_at) begin
            start_pend = 1'b1;
            start_op   = 32'd7;
         end
         tick();
      end
      lat = done_seen ? done_cyc - t0 : -1;
      if (!done_seen) check("done_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic check_writes(input string tag, input logic [31:0] op);
      logic [15:0] ea [4];
      logic [31:0] ed [4];
      ea = '{16'h7003, 16'h7004, 16'h7000, 16'h7001};
      ed = '{IE_EXP, op, 32'd1, 32'd1};
      check({tag, "_wr_count"}, 64'(wn), 64'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_wr%0d", tag, i), {16'b0, wa[i], wd[i]}, {16'b0, ea[i], ed[i]});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; m_grant = 1'b1; intr = 1'b0;
      operand = '0; m_din = '0;
      slave_setup(32'd0, 32'd0, 1'b0, 1'b0);
      repeat (3) begin
         rst_pend = 1'b1;
         tick();
      end
      tick();
      check("rst_busy",   64'(busy),   64'd0);
      check("rst_done",   64'(done),   64'd0);
      check("rst_error",  64'(error),  64'd0);
      check("rst_m_req",  64'(m_req),  64'd0);
      check("rst_m_wr",   64'(m_wr),   64'd0);
      check("rst_m_addr", 64'(m_addr), 64'd0);
      check("rst_m_dout", 64'(m_dout), 64'd0);
      check("rst_result", result,      64'd0);

      // basic: 5! = 120
      run_job(32'd5, 32'd0, 32'd120, 1'b1, 1'b0, 0);
      check("basic_lat",    64'(lat),      64'd21);
      check("basic_err",    64'(done_err), 64'd0);
      check("basic_result", done_res,      64'd120);
      check_writes("basic", 32'd5);
      repeat (3) tick();
      check("basic_hold_result", result,     64'd120);
      check("basic_idle_busy",   64'(busy),  64'd0);
      check("basic_one_done",    64'(ndone), 64'd1);

      // large 64-bit result: 20!
      run_job(32'd20, 32'h21C3677C, 32'h82B40000, 1'b1, 1'b0, 0);
      check("large_result", done_res,      64'h21C3677C82B40000);
      check("large_err",    64'(done_err), 64'd0);
      check("large_lat",    64'(lat),      64'd21);

      // grant drops for 3 cycles after the OPERAND write
      run_job(32'd6, 32'd0, 32'd720, 1'b1, 1'b1, 0);
      check("stall_lat",     64'(lat),       64'd24);
      check("stall_result",  done_res,       64'd720);
      check("stall_addr",    64'(st_addr),   64'h7000);
      check("stall_wr",      64'(st_wr),     64'd1);
      check("stall_req",     64'(st_req),    64'd1);
      check("stall_go_cyc",  64'(wc[2] - t0), 64'd7);
      check_writes("stall", 32'd6);

      // start with operand 7 while busy must be ignored
      run_job(32'd5, 32'd0, 32'd120, 1'b1, 1'b0, 8);
      check("ign_result", done_res,      64'd120);
      check("ign_lat",    64'(lat),      64'd21);
      check_writes("ign", 32'd5);
      tick();
      check("ign_no_restart", 64'(busy), 64'd0);

      // no completion: abort after TIMEOUT wait cycles
      run_job(32'd9, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 0);
      check("to_err",    64'(done_err), 64'd1);
      check("to_result", done_res,      64'd0);
      check("to_lat",    64'(lat),      64'(LAT_TO));
      check_writes("to", 32'd9);

      // reset while waiting for completion
      slave_setup(32'd0, 32'd24, 1'b1, 1'b0);
      start_pend = 1'b1;
      start_op   = 32'd4;
      tick();
      t0 = cyc;
      repeat (7) tick();
      rst_pend = 1'b1;
      tick();
      armed = 1'b0;
      tick();
      check("mid_rst_m_req", 64'(m_req), 64'd0);
      check("mid_rst_busy",  64'(busy),  64'd0);
      repeat (30) tick();
      check("mid_rst_no_done", 64'(ndone), 64'd0);
      run_job(32'd4, 32'd0, 32'd24, 1'b1, 1'b0, 0);
      check("after_rst_result", done_res,      64'd24);
      check("after_rst_err",    64'(done_err), 64'd0);
      check("after_rst_lat",    64'(lat),      64'd21);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
